// File: rtl/seg_scan_mux.sv
// seg_scan_mux: scan-tick edge detect, blanked 4-digit anode ring and active-low BCD seven-segment drive
module seg_scan_mux #(
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic        enable,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        scan_tick
);
  typedef enum logic {SHOW, BLANK} state_t;
  localparam logic [7:0] LAST = 8'(BLANK_CYCLES == 0 ? 0 : BLANK_CYCLES - 1);
  state_t      state;
  logic        prev;
  logic [1:0]  idx;
  logic [7:0]  cnt;
  logic        tick, sup, on, z3, z2, z1;
  logic [3:0]  nib;
  logic [6:0]  dec;
  // rising-edge detect, selected nibble, leading-zero test and segment decode
  always_comb begin
    tick = scan_clk & ~prev;
    on = enable && state == SHOW;
    nib = digits[{idx, 2'b00} +: 4];
    z3 = digits[15:12] == 4'h0;
    z2 = z3 && digits[11:8] == 4'h0;
    z1 = z2 && digits[7:4] == 4'h0;
    sup = LZ_BLANK && (idx == 2'd3 ? z3 : idx == 2'd2 ? z2 : idx == 2'd1 ? z1 : 1'b0);
    case (nib)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  end
  // scan ring FSM with blanking gap; outputs register the pre-edge selection
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= scan_clk;
      idx <= 2'd0;
      state <= SHOW;
      cnt <= 8'd0;
      an <= 4'hF;
      seg <= 7'h7F;
      dp <= 1'b1;
      digit_sel <= 2'd0;
      scan_tick <= 1'b0;
    end else begin
      prev <= scan_clk;
      scan_tick <= tick;
      digit_sel <= idx;
      an <= on ? ~(4'b0001 << idx) : 4'hF;
      seg <= on && !sup ? dec : 7'h7F;
      dp <= on ? ~dp_mask[idx] : 1'b1;
      if (tick) begin
        idx <= idx + 2'd1;
        state <= BLANK_CYCLES == 0 ? SHOW : BLANK;
        cnt <= 8'd0;
      end else if (state == BLANK) begin
        cnt <= cnt + 8'd1;
        if (cnt == LAST) state <= SHOW;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed stimulus with a cycle-tagged expectation queue checked by a separate monitor
module tb_seg_scan_mux;
  logic        clk = 1'b0;
  logic        reset, scan_clk, enable;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        scan_tick;
  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  sel;
    logic        tick;
  } exp_t;
  exp_t  q[$];
  string nq[$];
  exp_t  r;
  string rn;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  logic [3:0] an_t [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_t [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic       dp_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  seg_scan_mux dut (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .enable(enable),
    .digits(digits), .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp),
    .digit_sel(digit_sel), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int d, input string n, input logic [3:0] a, input logic [6:0] s,
                           input logic p, input logic [1:0] i, input logic t);
    q.push_back('{cyc: 32'(cyc + d), an: a, seg: s, dp: p, sel: i, tick: t});
    nq.push_back(n);
  endtask

  task automatic scan(input logic [3:0] ao, input logic [6:0] so, input logic po, input logic [1:0] io,
                      input logic [3:0] an_n, input logic [6:0] sn, input logic pn, input logic [1:0] in_);
    scan_clk = 1'b1;
    expect_at(1, "tick_old_digit", ao, so, po, io, 1'b1);
    for (int d = 2; d <= 5; d++) expect_at(d, "blank_gap", 4'hF, 7'h7F, 1'b1, in_, 1'b0);
    expect_at(6, "new_digit", an_n, sn, pn, in_, 1'b0);
    expect_at(7, "new_digit_hold", an_n, sn, pn, in_, 1'b0);
    step();
    scan_clk = 1'b0;
    repeat (7) step();
  endtask

  // compares every expectation whose target cycle has been reached
  always @(negedge clk) begin
    while (q.size() > 0 && int'(q[0].cyc) <= cyc) begin
      r = q.pop_front();
      rn = nq.pop_front();
      checks++;
      if (int'(r.cyc) != cyc || an !== r.an || seg !== r.seg || dp !== r.dp ||
          digit_sel !== r.sel || scan_tick !== r.tick) begin
        errors++;
        $display("FAIL %s cyc=%0d got an=%h seg=%h dp=%b sel=%0d tick=%b want cyc=%0d an=%h seg=%h dp=%b sel=%0d tick=%b",
                 rn, cyc, an, seg, dp, digit_sel, scan_tick, r.cyc, r.an, r.seg, r.dp, r.sel, r.tick);
      end
    end
  end

  initial begin
    reset = 1'b1;
    scan_clk = 1'b1;
    enable = 1'b1;
    digits = 16'h1234;
    dp_mask = 4'b0100;
    repeat (3) step();
    expect_at(0, "reset_state", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
    reset = 1'b0;
    expect_at(1, "first_lit_no_tick", 4'hE, 7'h19, 1'b1, 2'd0, 1'b0);
    step();
    scan_clk = 1'b0;
    expect_at(1, "digit0_steady", 4'hE, 7'h19, 1'b1, 2'd0, 1'b0);
    step();
    for (int k = 0; k < 8; k++)
      scan(an_t[k % 4], seg_t[k % 4], dp_t[k % 4], 2'(k % 4),
           an_t[(k + 1) % 4], seg_t[(k + 1) % 4], dp_t[(k + 1) % 4], 2'((k + 1) % 4));
    scan_clk = 1'b1;
    expect_at(1, "held_high_tick", 4'hE, 7'h19, 1'b1, 2'd0, 1'b1);
    expect_at(2, "held_high_no_retick", 4'hF, 7'h7F, 1'b1, 2'd1, 1'b0);
    expect_at(3, "held_high_no_retick2", 4'hF, 7'h7F, 1'b1, 2'd1, 1'b0);
    expect_at(8, "held_high_lit", 4'hD, 7'h30, 1'b1, 2'd1, 1'b0);
    repeat (10) step();
    scan_clk = 1'b0;
    step();
    digits = 16'h0050;
    expect_at(1, "lz_digit1", 4'hD, 7'h12, 1'b1, 2'd1, 1'b0);
    step();
    scan(4'hD, 7'h12, 1'b1, 2'd1, 4'hB, 7'h7F, 1'b0, 2'd2);
    scan(4'hB, 7'h7F, 1'b0, 2'd2, 4'h7, 7'h7F, 1'b1, 2'd3);
    scan(4'h7, 7'h7F, 1'b1, 2'd3, 4'hE, 7'h40, 1'b1, 2'd0);
    digits = 16'h000B;
    expect_at(1, "dash_digit0", 4'hE, 7'h3F, 1'b1, 2'd0, 1'b0);
    step();
    scan_clk = 1'b1;
    expect_at(1, "bt_first_tick", 4'hE, 7'h3F, 1'b1, 2'd0, 1'b1);
    expect_at(2, "bt_blank1", 4'hF, 7'h7F, 1'b1, 2'd1, 1'b0);
    expect_at(3, "bt_second_tick", 4'hF, 7'h7F, 1'b1, 2'd1, 1'b1);
    for (int d = 4; d <= 7; d++) expect_at(d, "bt_restarted_blank", 4'hF, 7'h7F, 1'b1, 2'd2, 1'b0);
    expect_at(8, "bt_lit_idx2", 4'hB, 7'h7F, 1'b0, 2'd2, 1'b0);
    expect_at(9, "bt_lit_hold", 4'hB, 7'h7F, 1'b0, 2'd2, 1'b0);
    step();
    scan_clk = 1'b0;
    step();
    scan_clk = 1'b1;
    step();
    scan_clk = 1'b0;
    repeat (7) step();
    enable = 1'b0;
    expect_at(1, "disable_dark", 4'hF, 7'h7F, 1'b1, 2'd2, 1'b0);
    step();
    scan_clk = 1'b1;
    expect_at(1, "disabled_tick", 4'hF, 7'h7F, 1'b1, 2'd2, 1'b1);
    for (int d = 2; d <= 7; d++) expect_at(d, "disabled_dark", 4'hF, 7'h7F, 1'b1, 2'd3, 1'b0);
    step();
    scan_clk = 1'b0;
    repeat (6) step();
    enable = 1'b1;
    expect_at(1, "reenable_lit", 4'h7, 7'h7F, 1'b1, 2'd3, 1'b0);
    step();
    step();
    scan(4'h7, 7'h7F, 1'b1, 2'd3, 4'hE, 7'h3F, 1'b1, 2'd0);
    scan_clk = 1'b1;
    expect_at(1, "rb_tick", 4'hE, 7'h3F, 1'b1, 2'd0, 1'b1);
    expect_at(2, "rb_blank", 4'hF, 7'h7F, 1'b1, 2'd1, 1'b0);
    step();
    scan_clk = 1'b0;
    step();
    reset = 1'b1;
    expect_at(1, "reset_mid_blank", 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
    step();
    reset = 1'b0;
    expect_at(1, "after_reset_lit", 4'hE, 7'h3F, 1'b1, 2'd0, 1'b0);
    expect_at(2, "after_reset_hold", 4'hE, 7'h3F, 1'b1, 2'd0, 1'b0);
    step();
    for (int w = 0; w < 20 && q.size() > 0; w++) step();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
